// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB3 slave register bank for the visible-watermarking engine.
// Holds CTRL (START/DONE), WhitePixel, eight configuration registers and the
// pixel storage, plus a registered read port for the embedding core.
// While START is high, writes to every register except CTRL are dropped.
// Optional feature: define APB_SLVERR_EN to report illegal accesses on pslverr.
// Without it, pslverr is tied low and illegal accesses are silent no-ops.
module apb_reg_bank #(
    parameter int AMBA_WORD       = 16,
    parameter int AMBA_ADDR_DEPTH = 20,
    parameter int NUM_REGS        = 42,
    parameter int WHITE_PIXEL_RST = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_ADDR_DEPTH-1:0] paddr,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic                       start,
    input  logic                       core_done,
    input  logic                       core_rd_en,
    input  logic [AMBA_ADDR_DEPTH-1:0] core_addr,
    output logic [AMBA_WORD-1:0]       core_rdata
);

    localparam int                       IDX_W      = $clog2(NUM_REGS);
    localparam logic [AMBA_ADDR_DEPTH:0] NUM_REGS_L = (AMBA_ADDR_DEPTH+1)'(NUM_REGS);
    localparam logic [AMBA_WORD-1:0]     WHITE_RST  = AMBA_WORD'(WHITE_PIXEL_RST);
    localparam logic [AMBA_WORD-1:0]     WORD_ZERO  = {AMBA_WORD{1'b0}};
    localparam logic [AMBA_ADDR_DEPTH-1:0] ADDR_ZERO = {AMBA_ADDR_DEPTH{1'b0}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [AMBA_WORD-1:0] regs_q [NUM_REGS];   // entry 0 is never used; CTRL lives in start_q/done_q
    logic                 start_q, start_d;
    logic                 done_q, done_d;
    logic [AMBA_WORD-1:0] prdata_q, prdata_d;
    logic [AMBA_WORD-1:0] core_rdata_q, core_rdata_d;

    logic                 setup_s;
    logic                 access_s;
    logic                 valid_access_s;
    logic                 apb_in_range_s;
    logic                 core_in_range_s;
    logic                 apb_is_ctrl_s;
    logic                 core_is_ctrl_s;
    logic                 ctrl_wr_s;
    logic                 data_wr_s;
    logic [AMBA_WORD-1:0] ctrl_word_s;
    logic [AMBA_WORD-1:0] apb_rd_val_s;
    logic [AMBA_WORD-1:0] core_rd_val_s;

    assign setup_s         = psel & ~penable;
    assign access_s        = psel & penable;
    // An ACCESS phase only counts when the previous cycle was SETUP.
    assign valid_access_s  = access_s & (state_q == ST_SETUP);
    assign apb_in_range_s  = ({1'b0, paddr} < NUM_REGS_L);
    assign core_in_range_s = ({1'b0, core_addr} < NUM_REGS_L);
    assign apb_is_ctrl_s   = (paddr == ADDR_ZERO);
    assign core_is_ctrl_s  = (core_addr == ADDR_ZERO);
    assign ctrl_word_s     = {{(AMBA_WORD-2){1'b0}}, done_q, start_q};

    // A CTRL write that lands in the same cycle as core_done is discarded.
    assign ctrl_wr_s = valid_access_s & pwrite & apb_is_ctrl_s & ~core_done;
    // Data/config writes are locked out while the core is running.
    assign data_wr_s = valid_access_s & pwrite & apb_in_range_s & ~apb_is_ctrl_s & ~start_q;

    // Zero wait states: every access-phase cycle completes immediately.
    assign pready = rst & access_s;

`ifdef APB_SLVERR_EN
    logic viol_s;
    logic busy_s;
    logic coll_s;
    logic illegal_s;

    assign viol_s    = access_s & (state_q != ST_SETUP);
    assign busy_s    = pwrite & apb_in_range_s & ~apb_is_ctrl_s & start_q;
    assign coll_s    = pwrite & apb_is_ctrl_s & core_done;
    assign illegal_s = viol_s | (valid_access_s & (~apb_in_range_s | busy_s | coll_s));
    assign pslverr   = rst & illegal_s;
`else
    assign pslverr   = 1'b0;
`endif

    assign prdata     = prdata_q;
    assign core_rdata = core_rdata_q;
    assign start      = start_q;

    // APB phase tracking: the bus phase of this cycle becomes the next state.
    always_comb begin
        state_d = ST_IDLE;
        if (!psel) begin
            state_d = ST_IDLE;
        end else if (!penable) begin
            state_d = ST_SETUP;
        end else begin
            state_d = ST_ACCESS;
        end
    end

    // Read mux for both ports; out-of-range addresses read as zero.
    always_comb begin
        apb_rd_val_s  = WORD_ZERO;
        core_rd_val_s = WORD_ZERO;
        if (!apb_in_range_s) begin
            apb_rd_val_s = WORD_ZERO;
        end else if (apb_is_ctrl_s) begin
            apb_rd_val_s = ctrl_word_s;
        end else begin
            apb_rd_val_s = regs_q[paddr[IDX_W-1:0]];
        end
        if (!core_in_range_s) begin
            core_rd_val_s = WORD_ZERO;
        end else if (core_is_ctrl_s) begin
            core_rd_val_s = ctrl_word_s;
        end else begin
            core_rd_val_s = regs_q[core_addr[IDX_W-1:0]];
        end
    end

    // Read data capture: APB at the end of SETUP, core whenever it requests.
    always_comb begin
        prdata_d     = prdata_q;
        core_rdata_d = core_rdata_q;
        if (setup_s && !pwrite) begin
            prdata_d = apb_rd_val_s;
        end else begin
            prdata_d = prdata_q;
        end
        if (core_rd_en) begin
            core_rdata_d = core_rd_val_s;
        end else begin
            core_rdata_d = core_rdata_q;
        end
    end

    // START/DONE: core completion has priority; a host write sets or clears START.
    always_comb begin
        start_d = start_q;
        done_d  = done_q;
        if (core_done && start_q) begin
            start_d = 1'b0;
            done_d  = 1'b1;
        end else if (ctrl_wr_s) begin
            start_d = pwdata[0];
            if (pwdata[0]) begin
                done_d = 1'b0;
            end else begin
                done_d = done_q;
            end
        end else begin
            start_d = start_q;
            done_d  = done_q;
        end
    end

    // Control, phase and read-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            prdata_q     <= WORD_ZERO;
            core_rdata_q <= WORD_ZERO;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            done_q       <= done_d;
            prdata_q     <= prdata_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    // Register file: WhitePixel resets to its configured value, all else to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 1) ? WHITE_RST : WORD_ZERO;
            end
        end else if (data_wr_s) begin
            regs_q[paddr[IDX_W-1:0]] <= pwdata;
        end
    end

endmodule

// File: doc/apb_reg_bank.md
# apb_reg_bank

Parametrised APB3 slave register bank for the visible-watermarking engine. It holds the control and configuration registers and the primary/watermark pixel storage. It exposes a proper PSEL/PENABLE/PREADY/PSLVERR handshake to the host, plus an independent registered read port to the embedding core. It also provides a start/done handshake that locks the configuration while the core is running.

## Interface
Parameters:
- AMBA_WORD, 16, data width of every register
- AMBA_ADDR_DEPTH, 20, APB/core address width in bits
- NUM_REGS, 42, number of implemented registers (addresses 0..NUM_REGS-1); must be ≥ 10 and ≤ 2^AMBA_ADDR_DEPTH
- WHITE_PIXEL_RST, 255, reset value of register 1 (WhitePixel)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  AMBA_ADDR_DEPTH  APB word address
- pwdata  in  AMBA_WORD  APB write data
- prdata  out  AMBA_WORD  APB read data, registered
- pready  out  1  transfer complete
- pslverr  out  1  transfer error; only meaningful with APB_SLVERR_EN
- start  out  1  CTRL[0]; core runs while high
- core_done  in  1  single-cycle pulse from the core at end of processing
- core_rd_en  in  1  core read request
- core_addr  in  AMBA_ADDR_DEPTH  core read address
- core_rdata  out  AMBA_WORD  core read data, registered

## Operation
- Register map:
  - 0 CTRL: bit0 START (RW); bit1 DONE (RO, sticky); other bits read 0.
  - 1 WhitePixel.
  - 2..9 configuration: PrimarySize, WatermarkSize, BlockSize, EdgeThreshold, A_min, A_max, B_min, B_max.
  - 10..NUM_REGS-1 pixel storage.
- APB FSM states:
  - IDLE: psel=0.
  - SETUP: psel=1, penable=0 → goes to ACCESS.
  - ACCESS: psel=1, penable=1 → IDLE if psel drops, SETUP if psel stays high with penable low.
  - penable=1 without a preceding SETUP is a protocol violation: no register change; pready=1; pslverr=1 (with macro).
- Write: the register updates at the rising edge ending the ACCESS cycle.
- Read: prdata loads at the rising edge ending SETUP and is stable throughout ACCESS. It holds its value otherwise.
- Illegal accesses, committed as no-ops:
  - paddr ≥ NUM_REGS: reads return 0.
  - Writes to addresses 1..NUM_REGS-1 while START=1 (busy lock).
  - Write to CTRL while core_done is high in the same cycle: the write is discarded.
- CTRL write with pwdata[0]=1 sets START and clears DONE. A write with pwdata[0]=0 clears START and leaves DONE unchanged.
- core_done=1 while START=1: START←0, DONE←1. core_done while START=0 is ignored.
- Core port: core_rdata ← reg[core_addr] one cycle after core_rd_en=1. It returns 0 if out of range and holds when core_rd_en=0. The core port never blocks APB.
- Same-cycle APB write and core read of the same address: core_rdata returns the old value.

## Timing
- Zero wait states: pready=1 in every ACCESS cycle, otherwise 0.
- A write completes in 2 cycles (SETUP+ACCESS); read data is valid in the ACCESS cycle.
- Core read latency: 1 cycle; one read per cycle sustained.
- START rises the cycle after the ACCESS edge that writes CTRL and falls the cycle after the core_done edge.
- Reset (asynchronous, any time including mid-transfer):
  - FSM returns to IDLE; CTRL=0; reg1=WHITE_PIXEL_RST; all other registers 0.
  - prdata, core_rdata, pready, pslverr and start all 0.
  - An in-flight transfer is dropped.

## Configuration
- APB_SLVERR_EN defined: pslverr=1 together with pready in the ACCESS cycle of every illegal access (out-of-range, busy-locked write, CTRL write colliding with core_done, protocol violation); 0 otherwise.
- APB_SLVERR_EN undefined: pslverr tied to 0; illegal accesses are still silent no-ops with identical register behaviour.

## Test plan
- Reset check: deassert rst, read addresses 0,1,2 → 0x0000, 0x00FF, 0x0000; pready=1 only in ACCESS, pslverr=0.
- Write/read-back: write 0x1234 to addr 10, then read addr 10 → prdata=0x1234 in the ACCESS cycle. Then core_rd_en with core_addr=10 → core_rdata=0x1234 one cycle later.
- Busy lock: write CTRL=1, then write 0x00AA to addr 2 → addr 2 unchanged, pslverr=1 (with macro). Pulse core_done → start=0, CTRL reads 0x0002; the retried write succeeds.
- Collision: APB write of CTRL=1 in the same cycle as core_done with START=1 → START=0, DONE=1, pslverr=1 (with macro).
- Out of range: read addr NUM_REGS → 0x0000 with pslverr=1 (with macro) or 0 (without); core read of the same address → 0.
- Mid-transfer reset: assert rst during the ACCESS cycle of a write of 0x5555 to addr 3 → addr 3=0 after reset, pready=0, and the FSM accepts a new transfer cleanly.
